// File: rtl/vga_reg_scheduler_if.sv
// vga_reg_scheduler_if: frame pacing, register sources and overlay outputs of the vgaREG scheduler.
interface vga_reg_scheduler_if;
    logic        endframe;
    logic [63:0] regs;
    logic [3:0]  req;
    logic [15:0] register;
    logic [1:0]  sel;
    logic        visible;
    logic [2:0]  zoom;
    logic [9:0]  x_pos;
    logic [9:0]  y_pos;
    logic        frame_tick;
    logic        led;
    modport master(output endframe, regs, req,
                   input register, sel, visible, zoom, x_pos, y_pos, frame_tick, led);
    modport slave(input endframe, regs, req,
                  output register, sel, visible, zoom, x_pos, y_pos, frame_tick, led);
endinterface

// File: rtl/vga_reg_scheduler.sv
// vga_reg_scheduler: round-robin time-sharing of the vgaREG overlay between 4 sources, paced by endframe.
// Optional VGA_REG_SCHED_PRIO_EN gives source 0 absolute priority.
module vga_reg_scheduler #(
    parameter int DWELL  = 16,
    parameter int ZSTEP  = 8,
    parameter int ZMIN   = 1,
    parameter int ZMAX   = 3,
    parameter int X_BASE = 16,
    parameter int X_STEP = 144,
    parameter int Y_BASE = 200
) (
    input logic px_clk,
    input logic rst_n,
    vga_reg_scheduler_if.slave bus
);
    localparam logic [0:0] UP   = 1'b0;
    localparam logic [0:0] DOWN = 1'b1;

    logic       endframe_q;
    logic [7:0] frame_cnt;
    logic [7:0] dwell;
    logic [7:0] zstep;
    logic [0:0] zstate;
    logic [0:0] zstate_n;
    logic [1:0] sel_n;
    logic       vis_n;
    logic       adv;
    logic       zadv;
    logic       prio;
    logic [2:0] zoom_n;
    logic [31:0] x_full;

    // The current source is the last candidate, so it keeps the slot only if nobody else asks.
    function automatic logic [1:0] rr_pick(input logic [1:0] s, input logic [3:0] r);
        logic [1:0] p;
        p = s;
        for (int k = 4; k >= 1; k--)
            if (r[2'(int'(s) + k)]) p = 2'(int'(s) + k);
        return p;
    endfunction

    assign bus.frame_tick = bus.endframe & ~endframe_q & rst_n;
    assign bus.led = frame_cnt[7];

    always_comb begin
        adv = dwell == 8'(DWELL - 1);
        zadv = zstep == 8'(ZSTEP - 1);
`ifdef VGA_REG_SCHED_PRIO_EN
        prio = bus.req[0];
`else
        prio = 1'b0;
`endif
        sel_n = prio ? 2'd0 : (adv && |bus.req) ? rr_pick(bus.sel, bus.req) : bus.sel;
        vis_n = prio | (adv ? |bus.req : bus.visible & bus.req[bus.sel]);
        zoom_n = zstate == UP ? (bus.zoom < 3'(ZMAX) ? bus.zoom + 3'd1 : bus.zoom)
                              : (bus.zoom > 3'(ZMIN) ? bus.zoom - 3'd1 : bus.zoom);
        zstate_n = zstate == UP ? (zoom_n >= 3'(ZMAX) ? DOWN : UP)
                                : (zoom_n <= 3'(ZMIN) ? UP : DOWN);
        x_full = 32'(X_BASE + int'(sel_n) * X_STEP);
    end

    always_ff @(posedge px_clk) begin
        if (!rst_n) begin
            endframe_q   <= 1'b0;
            frame_cnt    <= 8'd0;
            dwell        <= 8'd0;
            zstep        <= 8'd0;
            zstate       <= UP;
            bus.register <= 16'd0;
            bus.sel      <= 2'd0;
            bus.visible  <= 1'b0;
            bus.zoom     <= 3'(ZMIN);
            bus.x_pos    <= 10'(X_BASE);
            bus.y_pos    <= 10'(Y_BASE);
        end else begin
            endframe_q <= bus.endframe;
            if (bus.frame_tick) begin
                frame_cnt    <= frame_cnt + 8'd1;
                dwell        <= (adv || prio) ? 8'd0 : dwell + 8'd1;
                zstep        <= zadv ? 8'd0 : zstep + 8'd1;
                if (zadv) begin
                    bus.zoom <= zoom_n;
                    zstate   <= zstate_n;
                end
                bus.sel      <= sel_n;
                bus.visible  <= vis_n;
                bus.register <= vis_n ? bus.regs[16*sel_n +: 16] : 16'd0;
                bus.x_pos    <= x_full[9:0];
                bus.y_pos    <= 10'(Y_BASE);
            end
        end
    end
endmodule

// File: tb/tb_vga_reg_scheduler.sv
// tb_vga_reg_scheduler: directed frames with hand-derived expectations, checked by a tick-driven scoreboard monitor.
module tb_vga_reg_scheduler;
    logic px_clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 px_clk = ~px_clk;

    vga_reg_scheduler_if bus();
    vga_reg_scheduler dut(.px_clk(px_clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        int          t;
        logic [1:0]  sel;
        logic        vis;
        logic [15:0] r;
        logic [2:0]  zoom;
        logic [9:0]  x;
        logic        led;
    } exp_t;

    exp_t sb[$];
    int tests = 0;
    int failed = 0;
    int t = 0;
    int n;
    logic [2:0]  zseq[4] = '{3'd1, 3'd2, 3'd3, 3'd2};
    logic [9:0]  xs[4]   = '{10'd16, 10'd160, 10'd304, 10'd448};
    logic [15:0] src[4]  = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD};

    function automatic void chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        tests++;
        if (a !== e) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endfunction

    // zoom after tick t follows the 1,2,3,2 cycle, one step every 8 ticks
    task automatic frame(input logic [1:0] s, input logic v, input logic [15:0] r);
        exp_t e;
        t++;
        e.t = t; e.sel = s; e.vis = v; e.r = r;
        e.zoom = zseq[(t / 8) % 4]; e.x = xs[s]; e.led = t >= 128;
        sb.push_back(e);
        @(posedge px_clk); #1 bus.endframe = 1'b1;
        repeat (2) @(posedge px_clk);
        #1 bus.endframe = 1'b0;
        repeat (2) @(posedge px_clk);
        #1;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge px_clk);
            if (bus.frame_tick) begin
                @(negedge px_clk);
                if (sb.size() == 0) chk("sb_empty", 32'd1, 32'd0);
                else begin
                    e = sb.pop_front();
                    chk($sformatf("t%0d sel", e.t), 32'(bus.sel), 32'(e.sel));
                    chk($sformatf("t%0d visible", e.t), 32'(bus.visible), 32'(e.vis));
                    chk($sformatf("t%0d register", e.t), 32'(bus.register), 32'(e.r));
                    chk($sformatf("t%0d zoom", e.t), 32'(bus.zoom), 32'(e.zoom));
                    chk($sformatf("t%0d x_pos", e.t), 32'(bus.x_pos), 32'(e.x));
                    chk($sformatf("t%0d y_pos", e.t), 32'(bus.y_pos), 32'd200);
                    chk($sformatf("t%0d led", e.t), 32'(bus.led), 32'(e.led));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        bus.endframe = 1'b0;
        bus.req = 4'd0;
        bus.regs = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA};
        for (int i = 0; i < 3; i++) begin
            @(posedge px_clk); #1 bus.endframe = ~bus.endframe;
            @(negedge px_clk);
            chk("reset_tick", 32'(bus.frame_tick), 32'd0);
        end
        chk("reset_register", 32'(bus.register), 32'd0);
        chk("reset_sel", 32'(bus.sel), 32'd0);
        chk("reset_visible", 32'(bus.visible), 32'd0);
        chk("reset_zoom", 32'(bus.zoom), 32'd1);
        chk("reset_x_pos", 32'(bus.x_pos), 32'd16);
        chk("reset_y_pos", 32'(bus.y_pos), 32'd200);
        chk("reset_led", 32'(bus.led), 32'd0);
        @(posedge px_clk); #1 rst_n = 1'b1; bus.endframe = 1'b0;
        repeat (2) @(posedge px_clk);
        #1;
        t = 1;
        e_push: begin
            exp_t e;
            e.t = 1; e.sel = 2'd0; e.vis = 1'b0; e.r = 16'd0;
            e.zoom = 3'd1; e.x = 10'd16; e.led = 1'b0;
            sb.push_back(e);
        end
        bus.endframe = 1'b1;
        n = 0;
        repeat (100) begin
            @(negedge px_clk);
            if (bus.frame_tick) n++;
        end
        @(posedge px_clk); #1 bus.endframe = 1'b0;
        chk("held_ticks", 32'(n), 32'd1);
        chk("frame_cnt", 32'(dut.frame_cnt), 32'd1);
        repeat (2) @(posedge px_clk);
        #1;
`ifdef VGA_REG_SCHED_PRIO_EN
        bus.req = 4'b0100;
        for (int k = 2; k <= 15; k++) frame(2'd0, 1'b0, 16'd0);
        for (int k = 16; k <= 19; k++) frame(2'd2, 1'b1, 16'hCCCC);
        bus.req = 4'b0101;
        frame(2'd0, 1'b1, 16'hAAAA);
        chk("prio_dwell", 32'(dut.dwell), 32'd0);
        bus.req = 4'b0100;
        for (int k = 21; k <= 35; k++) frame(2'd0, 1'b0, 16'd0);
        for (int k = 36; k <= 40; k++) frame(2'd2, 1'b1, 16'hCCCC);
`else
        bus.req = 4'b1111;
        for (int k = 2; k <= 64; k++)
            frame(k < 16 ? 2'd0 : 2'((k / 16) % 4), k >= 16, k < 16 ? 16'd0 : src[(k / 16) % 4]);
        bus.req = 4'b0100;
        for (int k = 65; k <= 79; k++) frame(2'd0, 1'b0, 16'd0);
        for (int k = 80; k <= 87; k++) frame(2'd2, 1'b1, 16'hCCCC);
        bus.regs[47:32] = 16'h1234;
        for (int k = 88; k <= 100; k++) frame(2'd2, 1'b1, 16'h1234);
        bus.req = 4'b0000;
        for (int k = 101; k <= 130; k++) frame(2'd2, 1'b0, 16'd0);
`endif
        repeat (4) @(posedge px_clk);
        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/vga_reg_scheduler.md
Name: vga_reg_scheduler

Overview:
- Time-shares the single vgaREG register overlay between 4 register sources.
- Every DWELL frames it advances round-robin to the next requesting source and presents that source's value, screen position and an animated zoom level.
- Sits between the debug/register producers and vgaREG, clocked by px_clk, and is paced by endframe from endframeVGA.
- All outputs change only at frame boundaries, so the overlay never tears mid-frame.

Parameters:
- DWELL, 16: frames each source is shown before advancing (1..255).
- ZSTEP, 8: frames between zoom steps (1..255).
- ZMIN, 1: minimum zoom (0..7).
- ZMAX, 3: maximum zoom (0..7, ZMAX >= ZMIN).
- X_BASE, 16: x_pos of source 0.
- X_STEP, 144: x_pos increment per source index.
- Y_BASE, 200: y_pos for all sources.

Ports:
- px_clk  in  1  pixel clock; the only clock.
- rst_n  in  1  synchronous reset, active low.
- endframe  in  1  end-of-frame level from endframeVGA; may stay high for many cycles.
- regs  in  64  four 16-bit sources; source i is in regs[16*i+15:16*i].
- req  in  4  request mask; bit i high means source i wants display time.
- register  out  16  value to display.
- sel  out  2  index of the source being shown.
- visible  out  1  high when a source is being shown.
- zoom  out  3  zoom level for vgaREG.
- x_pos  out  10  overlay x position.
- y_pos  out  10  overlay y position.
- frame_tick  out  1  one-cycle pulse on each rising edge of endframe.
- led  out  1  bit 7 of the frame counter.

Behaviour:
- Reset: sampled on px_clk when rst_n=0. Reset wins over any simultaneous event. Reset values:
  - register=0, sel=0, visible=0, zoom=ZMIN, x_pos=X_BASE, y_pos=Y_BASE, frame_tick=0, led=0.
  - Frame counter, dwell counter and zoom-step counter = 0; zoom FSM = UP.
- Frame tick:
  - endframe is registered once; frame_tick = endframe & ~endframe_q.
  - A held endframe produces exactly one tick.
  - The 8-bit frame counter increments on each tick and wraps 255 -> 0.
- All state below updates only in the cycle where frame_tick=1; outputs are registered and appear 1 cycle after the tick.
- Dwell counter:
  - Increments on each tick.
  - When it reaches DWELL-1 it clears to 0 and an advance occurs.
- Advance:
  - Search (sel+1), (sel+2), (sel+3), (sel+4) mod 4 in that order; pick the first index with req set. The current source is considered last.
  - If a match is found: sel = match, visible = 1.
  - If req = 0: sel is held and visible = 0.
- visible=0 means x_pos, y_pos and zoom are still driven normally, but register is forced to 0. The integrator gates the overlay with visible.
- Immediate cut-off: if req[sel] drops while visible=1, visible goes to 0 on the next tick. The next advance then proceeds normally.
- Every tick while visible=1 (not only on advance):
  - register = regs[16*sel +: 16] is re-sampled.
  - x_pos = X_BASE + sel*X_STEP, truncated to 10 bits.
  - y_pos = Y_BASE.
- Zoom FSM, states UP and DOWN:
  - zstep counter increments on each tick; at ZSTEP-1 it clears and the zoom steps.
  - UP: zoom+1. When zoom reaches ZMAX, go to DOWN.
  - DOWN: zoom-1. When zoom reaches ZMIN, go to UP.
  - ZMIN == ZMAX: zoom stays constant.
  - zoom never leaves [ZMIN, ZMAX].
- Simultaneous advance and zoom step on the same tick: both apply.
- led = frame_counter[7].

Optional Feature:
- Macro: VGA_REG_SCHED_PRIO_EN.
- Defined:
  - Source 0 has priority. If req[0]=1 at any tick, sel=0 and visible=1 immediately, and the dwell counter is cleared.
  - Round-robin resumes from index 1 once req[0] drops.
- Not defined: pure round-robin as described above; source 0 gets no special treatment.

Test Plan:
- Reset with rst_n=0 for 3 cycles while endframe toggles -> all outputs at reset values, frame_tick stays 0, zoom=1.
- endframe held high for 100 cycles -> exactly one frame_tick; frame counter = 1.
- req=4'b1111, DWELL=16, regs = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA} -> sel sequence 1,2,3,0 every 16 ticks; register = BBBB, CCCC, DDDD, AAAA; x_pos = 160, 304, 448, 16.
- req=4'b0100 starting from sel=0 -> sel=2 after the first advance and stays 2; req then set to 0 -> visible=0 on the next tick and register=0.
- ZSTEP=8, ZMIN=1, ZMAX=3 over 64 ticks -> zoom sequence 1,2,3,2,1,2,3,2, changing every 8 ticks.
- With VGA_REG_SCHED_PRIO_EN defined, sel=2 mid-dwell, req[0] raised -> sel=0 one cycle after the next tick and the dwell counter reads 0.
